// File: rtl/fpu_ds_if.sv
// fpu_ds_if: engine start/done handshake and result handoff bundle of the fdiv/fsqrt scheduler
interface fpu_ds_if;
  logic eng_start;
  logic eng_op;
  logic eng_done;
  logic [31:0] eng_result;
  logic res_valid;
  logic [31:0] res_data;
  logic [4:0] res_n;
  modport master(output eng_start, eng_op, res_valid, res_data, res_n, input eng_done, eng_result);
  modport slave(input eng_start, eng_op, res_valid, res_data, res_n, output eng_done, eng_result);
endinterface

// File: rtl/fpu_ds_scheduler.sv
// fpu_ds_scheduler: sequences the shared iterative fdiv/fsqrt engine and stalls IF/ID until its result returns.
// Optional watchdog abort enabled by defining FP_DS_TIMEOUT_EN.
module fpu_ds_scheduler #(
  parameter int CNT_W = 5,
  parameter int TIMEOUT = 24
) (
  input  logic clk,
  input  logic clrn,
  input  logic e,
  input  logic fdiv,
  input  logic fsqrt,
  input  logic [4:0] fd,
  fpu_ds_if.master ds,
  output logic st_ds,
  output logic [CNT_W-1:0] count_div,
  output logic [CNT_W-1:0] count_sqrt,
  output logic ds_err
);
`ifdef FP_DS_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic req, start, op_q, sat, tmo, fin;
  logic [CNT_W-1:0] cnt_sel;
  logic [31:0] res_q;
  logic [4:0] n_q;
  assign req = fdiv | fsqrt;
  assign start = clrn & (state == IDLE) & req & e;
  assign st_ds = clrn & req & (state != DONE);
  assign cnt_sel = op_q ? count_sqrt : count_div;
  assign sat = &cnt_sel;
  // abort on the cycle the counter steps onto TIMEOUT, so DONE shows count == TIMEOUT
  assign tmo = WD & (state == RUN) & ~ds.eng_done & (cnt_sel == CNT_W'(TIMEOUT - 1));
  assign fin = (state == RUN) & (ds.eng_done | tmo);
  assign ds.eng_start = start;
  assign ds.eng_op = (state == IDLE) ? (start & ~fdiv) : op_q;
  assign ds.res_valid = state == DONE;
  assign ds.res_data = res_q;
  assign ds.res_n = n_q;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (req & e) ? RUN : IDLE;
      RUN: state_nxt = fin ? DONE : RUN;
      DONE: state_nxt = e ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      op_q <= 1'b0;
      n_q <= '0;
      res_q <= '0;
      count_div <= '0;
      count_sqrt <= '0;
      ds_err <= 1'b0;
    end else begin
      if (start) begin
        op_q <= ~fdiv;
        n_q <= fd;
        if (fdiv) count_div <= '0;
        else count_sqrt <= '0;
      end
      if (state == RUN && !sat) begin
        if (op_q) count_sqrt <= count_sqrt + CNT_W'(1);
        else count_div <= count_div + CNT_W'(1);
      end
      if (fin) res_q <= tmo ? 32'h7fc00000 : ds.eng_result;
      if (tmo) ds_err <= 1'b1;
    end
endmodule

// File: tb/tb_fpu_ds_scheduler.sv
// tb_fpu_ds_scheduler: table-driven cycle vectors plus directed long-op, mid-op reset and watchdog sequences.
module tb_fpu_ds_scheduler;
  logic clk = 1'b0;
  logic clrn, e, fdiv, fsqrt, st_ds, ds_err;
  logic [4:0] fd, count_div, count_sqrt;
  int n_cmp = 0;
  int n_err = 0;
  fpu_ds_if dsif();
  fpu_ds_scheduler #(.CNT_W(5), .TIMEOUT(24)) dut (
    .clk(clk), .clrn(clrn), .e(e), .fdiv(fdiv), .fsqrt(fsqrt), .fd(fd), .ds(dsif),
    .st_ds(st_ds), .count_div(count_div), .count_sqrt(count_sqrt), .ds_err(ds_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fdiv, fsqrt, e, done;
    logic [31:0] result;
    logic [4:0] fd;
    logic st, start, op, rv;
    logic [31:0] rd;
    logic [4:0] rn, cd, cs;
  } vec_t;
  vec_t tv[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  initial begin
    int starts, stc, run;
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd7, 5'd0, 5'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40000000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd7, 5'd0, 5'd1};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hdeadbeef, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40000000, 5'd7, 5'd0, 5'd2};
    tv[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'd9, 5'd0, 5'd2};
    tv[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hc0490fdb, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'd9, 5'd1, 5'd2};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 32'hc0490fdb, 5'd9, 5'd2, 5'd2};
    tv[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'hc0490fdb, 5'd9, 5'd2, 5'd2};
    tv[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'hc0490fdb, 5'd4, 5'd0, 5'd2};
    for (int i = 16; i < 20; i++)
      tv[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'hc0490fdb, 5'd4, 5'(i - 15), 5'd2};
    clrn = 1'b0; e = 1'b0; fdiv = 1'b0; fsqrt = 1'b0; fd = '0;
    dsif.eng_done = 1'b0; dsif.eng_result = '0;
    @(negedge clk); #1;
    chk("rst st_ds", st_ds, 0);
    chk("rst res_valid", dsif.res_valid, 0);
    chk("rst res_data", dsif.res_data, 0);
    chk("rst counts", {count_div, count_sqrt}, 0);
    chk("rst ds_err", ds_err, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      fdiv = tv[i].fdiv; fsqrt = tv[i].fsqrt; e = tv[i].e; fd = tv[i].fd;
      dsif.eng_done = tv[i].done; dsif.eng_result = tv[i].result;
      #1;
      chk($sformatf("v%0d st_ds", i), st_ds, tv[i].st);
      chk($sformatf("v%0d eng_start", i), dsif.eng_start, tv[i].start);
      chk($sformatf("v%0d eng_op", i), dsif.eng_op, tv[i].op);
      chk($sformatf("v%0d res_valid", i), dsif.res_valid, tv[i].rv);
      chk($sformatf("v%0d res_data", i), dsif.res_data, tv[i].rd);
      chk($sformatf("v%0d res_n", i), dsif.res_n, tv[i].rn);
      chk($sformatf("v%0d count_div", i), count_div, tv[i].cd);
      chk($sformatf("v%0d count_sqrt", i), count_sqrt, tv[i].cs);
      @(negedge clk);
    end
    dsif.eng_done = 1'b0;
    #1;
    chk("pre-reset count_div", count_div, 5);
    clrn = 1'b0; fdiv = 1'b0;
    #1;
    chk("in-reset st_ds", st_ds, 0);
    chk("in-reset counts", {count_div, count_sqrt}, 0);
    chk("in-reset res_valid", dsif.res_valid, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk); #1;
    chk("post-reset eng_start", dsif.eng_start, 0);
    chk("post-reset res_valid", dsif.res_valid, 0);
    chk("post-reset res_data", dsif.res_data, 0);
    chk("post-reset counts", {count_div, count_sqrt}, 0);
    @(negedge clk);
    fdiv = 1'b1; fd = 5'd3; e = 1'b1; starts = 0; stc = 0;
    for (int k = 0; k <= 20; k++) begin
      dsif.eng_done = (k == 20);
      dsif.eng_result = (k == 20) ? 32'h3f800000 : 32'h0;
      #1;
      starts += int'(dsif.eng_start);
      stc += int'(st_ds);
      if (k == 0) chk("long eng_op", dsif.eng_op, 0);
      @(negedge clk);
    end
    dsif.eng_done = 1'b0;
    #1;
    chk("long starts", starts, 1);
    chk("long st_ds cycles", stc, 21);
    chk("long st_ds in DONE", st_ds, 0);
    chk("long res_valid", dsif.res_valid, 1);
    chk("long res_data", dsif.res_data, 32'h3f800000);
    chk("long res_n", dsif.res_n, 3);
    chk("long count_div", count_div, 20);
    @(negedge clk);
    fdiv = 1'b0;
    #1;
    chk("long back to IDLE", dsif.res_valid, 0);
`ifdef FP_DS_TIMEOUT_EN
    @(negedge clk);
    fdiv = 1'b1; fd = 5'd5; e = 1'b1;
    @(negedge clk); #1;
    run = 0;
    while (!dsif.res_valid && run < 40) begin
      run++;
      @(negedge clk); #1;
    end
    chk("wd run cycles", run, 24);
    chk("wd res_valid", dsif.res_valid, 1);
    chk("wd res_data", dsif.res_data, 32'h7fc00000);
    chk("wd count_div", count_div, 24);
    chk("wd ds_err", ds_err, 1);
    e = 1'b0; dsif.eng_done = 1'b1; dsif.eng_result = 32'h11111111;
    @(negedge clk); #1;
    chk("wd late done data", dsif.res_data, 32'h7fc00000);
    e = 1'b1; fdiv = 1'b0; dsif.eng_done = 1'b0;
    @(negedge clk); #1;
    chk("wd ds_err sticky", ds_err, 1);
`else
    chk("ds_err tied", ds_err, 0);
    run = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
